// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the five-stage RV32I pipeline.
// Resolves, in priority order, a data-memory wait, a taken branch/jump
// redirect and a load-use hazard, and drives the hold/bubble/flush
// controls of the PC and the pipeline registers. A watchdog turns an
// over-long data-memory wait into a sticky timeout error, and two 32-bit
// counters record stalled and flushed cycles.

module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [4:0]  i_id_rs1_num,
    input  logic [4:0]  i_id_rs2_num,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,

    input  logic        i_ex_valid,
    input  logic [6:0]  i_ex_opcode,
    input  logic [4:0]  i_ex_rd_num,
    input  logic        i_branch_taken,

    input  logic        i_mem_valid,
    input  logic        i_mem_ready,

    output logic        o_stall_pc,
    output logic        o_stall_if_id,
    output logic        o_stall_id_ex,
    output logic        o_stall_ex_mem,
    output logic        o_bubble_id_ex,
    output logic        o_bubble_mem_wb,
    output logic        o_flush_if_id,
    output logic        o_timeout,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cnt,
    output logic [31:0] o_flush_cnt
);

    localparam logic [6:0]  OPC_LOAD      = 7'b0000011;
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(MEM_TIMEOUT);
    localparam logic [31:0] WAIT_CNT_MAX  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [31:0] wait_cnt_q,  wait_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic        timeout_q,   timeout_d;

    // Raw hazard conditions seen this cycle
    logic miss;
    logic redirect;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;

    // Decisions made by the sequencer for this cycle
    logic hold_all;   // freeze the front of the pipe, bubble into MEM/WB
    logic resolve;    // the memory side is quiet, so branch/load-use apply

    // Decode the three hazard sources; x0 as a destination never hazards
    always_comb begin
        miss     = i_mem_valid & ~i_mem_ready;
        redirect = i_ex_valid & i_branch_taken;
        rs1_hit  = i_id_uses_rs1 & (i_id_rs1_num == i_ex_rd_num);
        rs2_hit  = i_id_uses_rs2 & (i_id_rs2_num == i_ex_rd_num);
        load_use = i_ex_valid
                 & (i_ex_opcode == OPC_LOAD)
                 & (i_ex_rd_num != 5'd0)
                 & (rs1_hit | rs2_hit);
    end

    // Next-state logic for the memory-wait sequencer and its watchdog
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        hold_all   = 1'b0;
        resolve    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (miss) begin
                    hold_all   = 1'b1;
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 32'd1;
                end else begin
                    resolve = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                if (!i_mem_ready) begin
                    hold_all = 1'b1;
                    // Saturate rather than wrap so a disabled watchdog
                    // never sees a misleading small count.
                    if (wait_cnt_q != WAIT_CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
                    if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_LIMIT)) begin
                        state_d   = ST_TIMEOUT;
                        timeout_d = 1'b1;
                    end
                end else begin
                    // Ready wins over a timeout due in the same cycle; the
                    // pending branch or load-use is resolved right here.
                    resolve    = 1'b1;
                    state_d    = ST_RUN;
                    wait_cnt_d = 32'd0;
                end
            end

            ST_TIMEOUT: begin
                // Only reset leaves this state; ready is ignored.
                hold_all = 1'b1;
            end

            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = 32'd0;
            end
        endcase
    end

    // Pipeline control outputs; reset forces the pipe into a flushed state
    always_comb begin
        o_stall_pc      = 1'b0;
        o_stall_if_id   = 1'b0;
        o_stall_id_ex   = 1'b0;
        o_stall_ex_mem  = 1'b0;
        o_bubble_id_ex  = 1'b0;
        o_bubble_mem_wb = 1'b0;
        o_flush_if_id   = 1'b0;

        if (!rst_n) begin
            o_flush_if_id   = 1'b1;
            o_bubble_id_ex  = 1'b1;
            o_bubble_mem_wb = 1'b1;
        end else if (hold_all) begin
            o_stall_pc      = 1'b1;
            o_stall_if_id   = 1'b1;
            o_stall_id_ex   = 1'b1;
            o_stall_ex_mem  = 1'b1;
            o_bubble_mem_wb = 1'b1;
        end else if (resolve && redirect) begin
            // The ID instruction is on the wrong path, so a load-use
            // hazard against it is irrelevant.
            o_flush_if_id   = 1'b1;
            o_bubble_id_ex  = 1'b1;
        end else if (resolve && load_use) begin
            // One bubble suffices: next cycle the load sits in MEM and
            // its result is forwardable.
            o_stall_pc      = 1'b1;
            o_stall_if_id   = 1'b1;
            o_bubble_id_ex  = 1'b1;
        end
    end

    // Performance counters wrap naturally at 32 bits
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, o_stall_pc};
        flush_cnt_d = flush_cnt_q + {31'd0, o_flush_if_id};
    end

    // State, watchdog and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_timeout   = timeout_q;
    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.

module tb_pipeline_hazard_ctrl;

    localparam int         TO_CYC = 4;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    // Control bundle: {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
    //                  bubble_id_ex, bubble_mem_wb, flush_if_id, timeout}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_WAIT = 8'b1111_0100;
    localparam logic [7:0] C_TO   = 8'b1111_0101;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_RD   = 8'b0000_1010;
    localparam logic [7:0] C_RST  = 8'b0000_1110;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  i_id_rs1_num, i_id_rs2_num;
    logic        i_id_uses_rs1, i_id_uses_rs2;
    logic        i_ex_valid;
    logic [6:0]  i_ex_opcode;
    logic [4:0]  i_ex_rd_num;
    logic        i_branch_taken;
    logic        i_mem_valid, i_mem_ready;

    logic        o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem;
    logic        o_bubble_id_ex, o_bubble_mem_wb, o_flush_if_id, o_timeout;
    logic [1:0]  o_state;
    logic [31:0] o_stall_cnt, o_flush_cnt;
    logic [7:0]  ctl;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int          m_state;     // 0 run, 1 waiting on memory, 2 timed out
    int          m_wcnt;      // stalled miss cycles so far in this access
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic        m_to;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO_CYC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_rs1_num   (i_id_rs1_num),
        .i_id_rs2_num   (i_id_rs2_num),
        .i_id_uses_rs1  (i_id_uses_rs1),
        .i_id_uses_rs2  (i_id_uses_rs2),
        .i_ex_valid     (i_ex_valid),
        .i_ex_opcode    (i_ex_opcode),
        .i_ex_rd_num    (i_ex_rd_num),
        .i_branch_taken (i_branch_taken),
        .i_mem_valid    (i_mem_valid),
        .i_mem_ready    (i_mem_ready),
        .o_stall_pc     (o_stall_pc),
        .o_stall_if_id  (o_stall_if_id),
        .o_stall_id_ex  (o_stall_id_ex),
        .o_stall_ex_mem (o_stall_ex_mem),
        .o_bubble_id_ex (o_bubble_id_ex),
        .o_bubble_mem_wb(o_bubble_mem_wb),
        .o_flush_if_id  (o_flush_if_id),
        .o_timeout      (o_timeout),
        .o_state        (o_state),
        .o_stall_cnt    (o_stall_cnt),
        .o_flush_cnt    (o_flush_cnt)
    );

    assign ctl = {o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem,
                  o_bubble_id_ex, o_bubble_mem_wb, o_flush_if_id, o_timeout};

    // Expected control bundle for the current inputs, from the priority rules
    function automatic logic [7:0] model_ctl();
        bit miss, redirect, lu;
        if (!rst_n)       return C_RST | {7'd0, m_to};
        if (m_state == 2) return C_TO;
        miss     = (m_state == 1) ? !i_mem_ready : (i_mem_valid && !i_mem_ready);
        redirect = i_ex_valid && i_branch_taken;
        lu       = i_ex_valid && (i_ex_opcode == OP_LOAD) && (i_ex_rd_num != 0) &&
                   ((i_id_uses_rs1 && i_id_rs1_num == i_ex_rd_num) ||
                    (i_id_uses_rs2 && i_id_rs2_num == i_ex_rd_num));
        if (miss)     return C_WAIT;
        if (redirect) return C_RD;
        if (lu)       return C_LU;
        return C_NONE;
    endfunction

    // Advance the model by one clock edge using the inputs held over it
    task automatic model_update();
        logic [7:0] e;
        e = model_ctl();
        if (!rst_n) begin
            m_state = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
            return;
        end
        m_stall = m_stall + {31'd0, e[7]};
        m_flush = m_flush + {31'd0, e[1]};
        case (m_state)
            0: if (i_mem_valid && !i_mem_ready) begin m_state = 1; m_wcnt = 1; end
            1: begin
                if (i_mem_ready) m_state = 0;
                else if (m_wcnt == TO_CYC) begin m_state = 2; m_to = 1; end
                else m_wcnt++;
            end
            default: ;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        i_id_rs1_num = 0; i_id_rs2_num = 0; i_id_uses_rs1 = 0; i_id_uses_rs2 = 0;
        i_ex_valid = 0; i_ex_opcode = OP_ALU; i_ex_rd_num = 0; i_branch_taken = 0;
        i_mem_valid = 0; i_mem_ready = 0;
    endtask

    task automatic set_load_use();
        set_idle();
        i_ex_valid = 1; i_ex_opcode = OP_LOAD; i_ex_rd_num = 5;
        i_id_rs1_num = 5; i_id_uses_rs1 = 1;
    endtask

    task automatic test_reset();
        rst_n = 0; set_idle();
        step();
        @(negedge clk);
        tests_run++;
        if (ctl !== C_RST) begin tests_failed++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
        tests_run++;
        if (o_state !== 2'd0 || o_stall_cnt !== 0 || o_flush_cnt !== 0) begin
            tests_failed++;
            $display("FAIL reset_regs: state %0d stall %0d flush %0d, want 0 0 0", o_state, o_stall_cnt, o_flush_cnt);
        end
        step();
        rst_n = 1;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE || o_state !== 2'd0) begin
            tests_failed++; $display("FAIL reset_release: ctl %b state %0d, want 0 0", ctl, o_state);
        end
        step();
    endtask

    task automatic test_load_use();
        set_load_use();
        @(negedge clk);
        tests_run++;
        if (ctl !== C_LU) begin tests_failed++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); end
        step();
        set_idle(); i_mem_valid = 1; i_mem_ready = 1;   // load now in MEM
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE || o_stall_cnt !== 32'd1) begin
            tests_failed++; $display("FAIL lu_one_bubble: ctl %b cnt %0d, want %b 1", ctl, o_stall_cnt, C_NONE);
        end
        step();
        set_load_use(); i_ex_rd_num = 0; i_id_rs1_num = 0;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE) begin tests_failed++; $display("FAIL lu_x0: got %b want %b", ctl, C_NONE); end
        step();
        set_load_use(); i_id_uses_rs1 = 0;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE) begin tests_failed++; $display("FAIL lu_unused_rs1: got %b want %b", ctl, C_NONE); end
        step();
        set_load_use(); i_id_uses_rs1 = 0; i_id_rs1_num = 0; i_id_rs2_num = 5; i_id_uses_rs2 = 1;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_LU) begin tests_failed++; $display("FAIL lu_rs2: got %b want %b", ctl, C_LU); end
        step();
    endtask

    task automatic test_redirect();
        set_load_use(); i_branch_taken = 1;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_RD) begin tests_failed++; $display("FAIL redirect_over_lu: got %b want %b", ctl, C_RD); end
        step();
        set_idle(); i_branch_taken = 1;   // branch flag on a bubble in EX
        @(negedge clk);
        tests_run++;
        if (o_flush_cnt !== 32'd1) begin tests_failed++; $display("FAIL redirect_cnt: got %0d want 1", o_flush_cnt); end
        tests_run++;
        if (ctl !== C_NONE) begin tests_failed++; $display("FAIL redirect_invalid_ex: got %b want %b", ctl, C_NONE); end
        step();
    endtask

    task automatic test_mem_wait();
        logic [31:0] base;
        base = m_stall;
        for (int i = 0; i < 3; i++) begin
            set_idle(); i_mem_valid = 1; i_mem_ready = 0;
            @(negedge clk);
            tests_run++;
            if (ctl !== C_WAIT || o_state !== ((i == 0) ? 2'd0 : 2'd1)) begin
                tests_failed++; $display("FAIL memwait_cyc%0d: ctl %b state %0d, want %b %0d", i, ctl, o_state, C_WAIT, (i == 0) ? 0 : 1);
            end
            step();
        end
        i_mem_ready = 1;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE || o_state !== 2'd1) begin
            tests_failed++; $display("FAIL memwait_ready: ctl %b state %0d, want %b 1", ctl, o_state, C_NONE);
        end
        step();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (o_state !== 2'd0 || o_stall_cnt !== base + 32'd3) begin
            tests_failed++; $display("FAIL memwait_done: state %0d cnt %0d, want 0 %0d", o_state, o_stall_cnt, base + 32'd3);
        end
        step();
    endtask

    task automatic test_miss_branch();
        logic [31:0] base;
        base = m_flush;
        for (int i = 0; i < 2; i++) begin
            set_idle(); i_ex_valid = 1; i_branch_taken = 1; i_mem_valid = 1; i_mem_ready = 0;
            @(negedge clk);
            tests_run++;
            if (ctl !== C_WAIT) begin tests_failed++; $display("FAIL missbr_wait%0d: got %b want %b", i, ctl, C_WAIT); end
            step();
        end
        i_mem_ready = 1;
        @(negedge clk);
        tests_run++;
        if (ctl !== C_RD) begin tests_failed++; $display("FAIL missbr_ready: got %b want %b", ctl, C_RD); end
        step();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (o_flush_cnt !== base + 32'd1 || o_state !== 2'd0) begin
            tests_failed++; $display("FAIL missbr_after: flush %0d state %0d, want %0d 0", o_flush_cnt, o_state, base + 32'd1);
        end
        step();
    endtask

    task automatic test_random();
        logic [7:0] e;
        for (int c = 0; c < 600; c++) begin
            rst_n          = !((m_state == 2) || ($urandom_range(0, 39) == 0));
            i_id_rs1_num   = 5'($urandom_range(0, 3));
            i_id_rs2_num   = 5'($urandom_range(0, 3));
            i_id_uses_rs1  = 1'($urandom_range(0, 1));
            i_id_uses_rs2  = 1'($urandom_range(0, 1));
            i_ex_valid     = ($urandom_range(0, 9) < 8);
            i_ex_opcode    = ($urandom_range(0, 1) == 1) ? OP_LOAD : OP_ALU;
            i_ex_rd_num    = 5'($urandom_range(0, 3));
            i_branch_taken = ($urandom_range(0, 4) == 0);
            i_mem_valid    = ($urandom_range(0, 9) < 4);
            i_mem_ready    = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            e = model_ctl();
            tests_run++;
            if (ctl !== e || o_state !== 2'(m_state) || o_stall_cnt !== m_stall || o_flush_cnt !== m_flush) begin
                tests_failed++;
                $display("FAIL random_c%0d: ctl %b state %0d stall %0d flush %0d, want %b %0d %0d %0d",
                         c, ctl, o_state, o_stall_cnt, o_flush_cnt, e, m_state, m_stall, m_flush);
            end
            step();
        end
        rst_n = 1; set_idle();
        step();
    endtask

    task automatic test_timeout();
        rst_n = 0; set_idle();
        step();
        rst_n = 1;
        for (int k = 1; k <= 5; k++) begin
            i_mem_valid = 1; i_mem_ready = 0;
            @(negedge clk);
            tests_run++;
            if (ctl !== C_WAIT || o_state !== ((k == 1) ? 2'd0 : 2'd1)) begin
                tests_failed++; $display("FAIL timeout_wait%0d: ctl %b state %0d, want %b %0d", k, ctl, o_state, C_WAIT, (k == 1) ? 0 : 1);
            end
            step();
        end
        @(negedge clk);
        tests_run++;
        if (ctl !== C_TO || o_state !== 2'd2) begin
            tests_failed++; $display("FAIL timeout_fire: ctl %b state %0d, want %b 2", ctl, o_state, C_TO);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            i_mem_ready = 1;
            @(negedge clk);
            tests_run++;
            if (ctl !== C_TO || o_state !== 2'd2) begin
                tests_failed++; $display("FAIL timeout_sticky%0d: ctl %b state %0d, want %b 2", k, ctl, o_state, C_TO);
            end
            step();
        end
        rst_n = 0;
        step();
        rst_n = 1; set_idle();
        @(negedge clk);
        tests_run++;
        if (ctl !== C_NONE || o_state !== 2'd0 || o_timeout !== 1'b0 || o_stall_cnt !== 0 || o_flush_cnt !== 0) begin
            tests_failed++;
            $display("FAIL timeout_clear: ctl %b state %0d stall %0d flush %0d, want 0 0 0 0", ctl, o_state, o_stall_cnt, o_flush_cnt);
        end
        step();
    endtask

    task automatic test_counter_wrap();
        set_idle();
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        tests_run++;
        if (o_stall_cnt !== 32'hFFFF_FFFF) begin
            tests_failed++; $display("FAIL wrap_preload: got %h want ffffffff", o_stall_cnt);
        end
        release dut.stall_cnt_q;
        set_load_use();
        #1;
        tests_run++;
        if (ctl !== C_LU) begin tests_failed++; $display("FAIL wrap_lu: got %b want %b", ctl, C_LU); end
        step();
        set_idle();
        @(negedge clk);
        tests_run++;
        if (o_stall_cnt !== 32'd0) begin tests_failed++; $display("FAIL wrap_zero: got %h want 00000000", o_stall_cnt); end
        step();
    endtask

    initial begin
        rst_n = 0;
        set_idle();
        m_state = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_to = 0;
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_miss_branch();
        test_random();
        test_timeout();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
